// File: rtl/lms_weight_update_pkg.sv
// Shared types and constants for the LMS weight updater.
// Optional leaky update is enabled by defining LMS_LEAK_EN.
package lms_pkg;

    localparam int TAPS  = 16;
    localparam int DW    = 14;
    localparam int EW    = 16;
    localparam int PW    = DW + EW;
    localparam int SW    = PW + 1;
    localparam int W_MAX = 8191;
    localparam int W_MIN = -8192;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } lms_state_e;

    // Clamp a wide signed sum into the weight range.
    function automatic logic signed [DW-1:0] sat_w(input logic signed [SW-1:0] s);
        logic signed [DW-1:0] r;
        if (s > SW'(W_MAX)) begin
            r = DW'(W_MAX);
        end else if (s < SW'(W_MIN)) begin
            r = DW'(W_MIN);
        end else begin
            r = s[DW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/lms_weight_update_if.sv
// Update-request / weight bus between the adaptive filter and its weight updater.
// The master side is the filter, the slave side is the updater.
interface lms_weight_update_if;
    import lms_pkg::*;

    logic                     adap_filter_state;
    logic                     clr;
    logic                     upd_valid;
    logic                     upd_ready;
    logic signed [EW-1:0]     e;
    logic [TAPS*DW-1:0]       reff_bus;
    logic [TAPS*DW-1:0]       weight_bus;
    logic                     upd_busy;
    logic                     upd_done;

    modport master (
        output adap_filter_state, clr, upd_valid, e, reff_bus,
        input  upd_ready, weight_bus, upd_busy, upd_done
    );

    modport slave (
        input  adap_filter_state, clr, upd_valid, e, reff_bus,
        output upd_ready, weight_bus, upd_busy, upd_done
    );

endinterface

// File: rtl/lms_weight_update_tap_mac.sv
// Single-tap LMS update: new weight = sat(w + ((e * reff) >>> MU_SHIFT)).
// With LMS_LEAK_EN defined, w >>> LEAK_SHIFT is subtracted before saturation.
module lms_tap_mac
    import lms_pkg::*;
#(
    parameter int MU_SHIFT = 12
`ifdef LMS_LEAK_EN
    ,
    parameter int LEAK_SHIFT = 10
`endif
) (
    input  logic signed [DW-1:0] w,
    input  logic signed [EW-1:0] e,
    input  logic signed [DW-1:0] reff,
    output logic signed [DW-1:0] w_new
);

    logic signed [PW-1:0] p_s;
    logic signed [PW-1:0] delta_s;
    logic signed [SW-1:0] sum_s;

    assign p_s     = PW'(e) * PW'(reff);
    assign delta_s = p_s >>> MU_SHIFT;

`ifdef LMS_LEAK_EN
    logic signed [DW-1:0] leak_s;
    // Leak is taken from the pre-update weight; saturation happens only once below.
    assign leak_s = w >>> LEAK_SHIFT;
    assign sum_s  = SW'(w) - SW'(leak_s) + SW'(delta_s);
`else
    assign sum_s  = SW'(w) + SW'(delta_s);
`endif

    assign w_new = sat_w(sum_s);

endmodule

// File: rtl/lms_weight_update.sv
// LMS coefficient updater: snapshots e and the reference taps, then rewrites one weight per clock.
// Define LMS_LEAK_EN to build the leaky-LMS variant.
module lms_weight_update
    import lms_pkg::*;
#(
    parameter int MU_SHIFT = 12
`ifdef LMS_LEAK_EN
    ,
    parameter int LEAK_SHIFT = 10
`endif
) (
    input  logic               clk,
    input  logic               rstn,
    lms_weight_update_if.slave bus
);

    lms_state_e           state_r;
    logic [3:0]           idx_r;
    logic                 busy_r;
    logic                 done_r;
    logic signed [EW-1:0] e_snap_r;
    logic signed [DW-1:0] reff_snap_r [TAPS];
    logic signed [DW-1:0] weights_r   [TAPS];
    logic signed [DW-1:0] mac_w_s;
    logic [TAPS*DW-1:0]   weight_bus_s;

    // The MAC only ever sees snapshotted operands, never the live bus.
    lms_tap_mac #(
        .MU_SHIFT   (MU_SHIFT)
`ifdef LMS_LEAK_EN
        ,
        .LEAK_SHIFT (LEAK_SHIFT)
`endif
    ) u_mac (
        .w     (weights_r[idx_r]),
        .e     (e_snap_r),
        .reff  (reff_snap_r[idx_r]),
        .w_new (mac_w_s)
    );

    assign bus.upd_ready  = (state_r == IDLE) && bus.adap_filter_state && !bus.clr;
    assign bus.upd_busy   = busy_r;
    assign bus.upd_done   = done_r;
    assign bus.weight_bus = weight_bus_s;

    // Pack the weight register file onto the output bus.
    always_comb begin
        weight_bus_s = '0;
        for (int k = 0; k < TAPS; k++) begin
            weight_bus_s[k*DW +: DW] = weights_r[k];
        end
    end

    // Sequencer, snapshot capture and weight register file.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= IDLE;
            idx_r    <= 4'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            e_snap_r <= '0;
            for (int k = 0; k < TAPS; k++) begin
                weights_r[k]   <= '0;
                reff_snap_r[k] <= '0;
            end
        end else if (bus.clr) begin
            state_r <= IDLE;
            idx_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                weights_r[k] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.upd_valid && bus.upd_ready) begin
                        e_snap_r <= bus.e;
                        for (int k = 0; k < TAPS; k++) begin
                            reff_snap_r[k] <= bus.reff_bus[k*DW +: DW];
                        end
                        idx_r   <= 4'd0;
                        busy_r  <= 1'b1;
                        state_r <= UPDATE;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                UPDATE: begin
                    if (!bus.adap_filter_state) begin
                        // Abort keeps whatever taps were already written.
                        idx_r   <= 4'd0;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        weights_r[idx_r] <= mac_w_s;
                        idx_r            <= idx_r + 4'd1;
                        if (idx_r == 4'(TAPS - 1)) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            busy_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    idx_r   <= 4'd0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    idx_r   <= 4'd0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lms_weight_update.sv
// Self-checking bench for lms_weight_update: cycle model compared every negedge plus directed pins.
// Leak-specific pins are selected when LMS_LEAK_EN is defined.
module tb_lms_weight_update;
    import lms_pkg::*;

    localparam int MU = 12;
`ifdef LMS_LEAK_EN
    localparam int LK = 10;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    lms_weight_update_if bus();

    lms_weight_update #(.MU_SHIFT(MU)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;
    int cyc = 0;
    int acc_cyc = 0;

    int m_w [TAPS];
    int m_r [TAPS];
    int m_e;
    int m_pos;
    bit m_active;
    bit m_done_ph;
    logic [TAPS*DW-1:0] exp_bus;

    function automatic int floor_shr(input int v, input int sh);
        int d;
        d = v / (1 << sh);
        if (v < 0 && (v % (1 << sh)) != 0) d = d - 1;
        return d;
    endfunction

    function automatic int new_weight(input int w, input int ev, input int r);
        int s;
        s = w + floor_shr(ev * r, MU);
`ifdef LMS_LEAK_EN
        s = s - floor_shr(w, LK);
`endif
        if (s > 8191) s = 8191;
        if (s < -8192) s = -8192;
        return s;
    endfunction

    function automatic logic [TAPS*DW-1:0] fill(input int v);
        logic [TAPS*DW-1:0] r;
        r = '0;
        for (int k = 0; k < TAPS; k++) r[k*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [TAPS*DW-1:0] one(input int k, input int v);
        logic [TAPS*DW-1:0] r;
        r = '0;
        r[k*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [TAPS*DW-1:0] ramp();
        logic [TAPS*DW-1:0] r;
        r = '0;
        for (int k = 0; k < TAPS; k++) r[k*DW +: DW] = DW'(k + 1);
        return r;
    endfunction

    // Cycle counter used for the latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: pass in progress, taps written so far, one-cycle done phase.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < TAPS; k++) m_w[k] <= 0;
            m_active  <= 1'b0;
            m_done_ph <= 1'b0;
            m_pos     <= 0;
        end else if (bus.clr) begin
            for (int k = 0; k < TAPS; k++) m_w[k] <= 0;
            m_active  <= 1'b0;
            m_done_ph <= 1'b0;
        end else if (m_active) begin
            if (!bus.adap_filter_state) begin
                m_active <= 1'b0;
            end else begin
                m_w[m_pos] <= new_weight(m_w[m_pos], m_e, m_r[m_pos]);
                m_pos      <= m_pos + 1;
                if (m_pos == TAPS - 1) begin
                    m_active  <= 1'b0;
                    m_done_ph <= 1'b1;
                end
            end
        end else if (m_done_ph) begin
            m_done_ph <= 1'b0;
        end else if (bus.upd_valid && bus.adap_filter_state) begin
            m_e <= int'(bus.e);
            for (int k = 0; k < TAPS; k++) m_r[k] <= int'($signed(bus.reff_bus[k*DW +: DW]));
            m_pos    <= 0;
            m_active <= 1'b1;
            acc_cyc  <= cyc;
        end
    end

    task automatic check_bus(input string name, input logic [TAPS*DW-1:0] got, input logic [TAPS*DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_tap(input int k, input int exp);
        check_int($sformatf("tap%0d", k), int'($signed(bus.weight_bus[k*DW +: DW])), exp);
    endtask

    // Compare process: every negedge, outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < TAPS; k++) exp_bus[k*DW +: DW] = DW'(m_w[k]);
            check_bus("weight_bus", bus.weight_bus, exp_bus);
            check_int("upd_busy", int'(bus.upd_busy), int'(m_active));
            check_int("upd_done", int'(bus.upd_done), int'(m_done_ph));
            check_int("upd_ready", int'(bus.upd_ready),
                      int'(!m_active && !m_done_ph && bus.adap_filter_state && !bus.clr));
            if (bus.upd_done) begin
                done_seen++;
                check_int("done_latency", cyc - acc_cyc, 17);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
    endtask

    task automatic run_pass(input int ev, input logic [TAPS*DW-1:0] rb);
        int n;
        n = 0;
        while (!bus.upd_ready && n < 20) begin
            tick();
            n++;
        end
        bus.e         = EW'(ev);
        bus.reff_bus  = rb;
        bus.upd_valid = 1'b1;
        tick();
        bus.upd_valid = 1'b0;
        n = 0;
        while (!bus.upd_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.upd_done) begin
            n_cmp++;
            n_err++;
            $display("FAIL pass_timeout: got no upd_done expected pulse within 40 cycles");
        end
        tick();
    endtask

    task automatic start_and_wait7(input int ev, input logic [TAPS*DW-1:0] rb);
        bus.e         = EW'(ev);
        bus.reff_bus  = rb;
        bus.upd_valid = 1'b1;
        tick();
        bus.upd_valid = 1'b0;
        repeat (7) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        bus.adap_filter_state = 1'b1;
        bus.clr       = 1'b0;
        bus.upd_valid = 1'b0;
        bus.e         = '0;
        bus.reff_bus  = '0;
        rstn          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        check_tap(0, 0);
        check_tap(15, 0);

        run_pass(4096, fill(100));
        check_tap(0, 100);
        check_tap(15, 100);
        check_int("done_count_first", done_seen, 1);

`ifndef LMS_LEAK_EN
        clear();
        run_pass(1, one(0, 1));
        check_tap(0, 0);
        run_pass(-1, one(0, 1));
        check_tap(0, -1);
        run_pass(-4096, one(0, 3));
        check_tap(0, -4);

        clear();
        run_pass(4096, one(3, 8100));
        check_tap(3, 8100);
        run_pass(4096, one(3, 200));
        check_tap(3, 8191);
        clear();
        run_pass(-4096, one(3, 8100));
        check_tap(3, -8100);
        run_pass(4096, one(3, -200));
        check_tap(3, -8192);
`else
        clear();
        run_pass(4096, one(0, 1024));
        check_tap(0, 1024);
        run_pass(0, fill(0));
        check_tap(0, 1023);
`endif

        // upd_valid held through most of a pass: only one acceptance
        base = done_seen;
        bus.e         = EW'(4096);
        bus.reff_bus  = fill(7);
        bus.upd_valid = 1'b1;
        repeat (10) tick();
        bus.upd_valid = 1'b0;
        repeat (40) tick();
        check_int("one_pass_per_accept", done_seen - base, 1);

        // clr at tap 7 aborts and zeroes everything
        base = done_seen;
        start_and_wait7(4096, fill(50));
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check_tap(0, 0);
        check_tap(7, 0);
        repeat (30) tick();
        check_int("clr_abort_no_done", done_seen - base, 0);

        // adaptation dropped at tap 7: taps 0..6 updated only
        clear();
        run_pass(4096, fill(100));
        base = done_seen;
        start_and_wait7(4096, ramp());
        bus.adap_filter_state = 1'b0;
        repeat (31) tick();
        bus.adap_filter_state = 1'b1;
        check_tap(0, 101);
        check_tap(6, 107);
        check_tap(7, 100);
        check_tap(15, 100);
        check_int("adap_abort_no_done", done_seen - base, 0);

        // reset mid-pass clears weights at once
        bus.e         = EW'(4096);
        bus.reff_bus  = fill(100);
        bus.upd_valid = 1'b1;
        tick();
        bus.upd_valid = 1'b0;
        repeat (5) tick();
        rstn = 1'b0;
        #1;
        check_tap(0, 0);
        check_tap(4, 0);
        tick();
        rstn = 1'b1;
        run_pass(4096, fill(100));
        check_tap(0, 100);
        check_tap(15, 100);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
